// File: rtl/clint_timer.sv
// clint_timer: machine-mode timer with 64-bit mtime/mtimecmp and an active-low interrupt
//
// Ports:
//   clk_i    system clock, all state updates on the rising edge
//   rst_i    asynchronous active-high reset
//   req_i    bus request, every cycle with req_i=1 is accepted
//   we_i     1 = write, 0 = read, qualified by req_i
//   addr_i   word offset: 0/1 mtime lo/hi, 2/3 mtimecmp lo/hi, 4 ctrl {autoclr, en}, 5..7 reserved
//   wdata_i  write data
//   rdata_o  read data, valid with ack_o and held until the next ack
//   ack_o    one-cycle acknowledge, the cycle after each accepted request
//   ti_o     timer interrupt, active low, registered from mtime >= mtimecmp
//
// Optional build macro CLINT_TIMER_SNAPSHOT_EN: a read of mtime lo latches mtime hi
// into a shadow that reads of addr 1 return, giving a tear-free lo-then-hi 64-bit read.
module clint_timer #(
    parameter int unsigned PRESCALE   = 1,
    parameter logic [31:0] RST_CMP_HI = 32'hFFFF_FFFF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [2:0]  addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        ack_o,
    output logic        ti_o
);
    logic [63:0] mtime_q, mtime_d, mtimecmp_q, mtimecmp_d;
    logic [15:0] pcnt_q, pcnt_d;
    logic [1:0]  ctrl_q, ctrl_d;
    logic [31:0] rdata_d, hi_rd;
    logic        wr, wr_mt, tick, match;

    assign wr    = req_i & we_i;
    assign wr_mt = wr && addr_i[2:1] == 2'b00;
    assign tick  = ctrl_q[0] && pcnt_q == 16'(PRESCALE - 1);
    assign match = mtime_q >= mtimecmp_q;

    // A bus write to either mtime half beats a coincident tick and restarts the prescaler.
    always_comb begin
        mtime_d    = (wr && addr_i == 3'd0) ? {mtime_q[63:32], wdata_i}
                   : (wr && addr_i == 3'd1) ? {wdata_i, mtime_q[31:0]}
                   : tick ? ((ctrl_q[1] && match) ? 64'd0 : mtime_q + 64'd1)
                   : mtime_q;
        pcnt_d     = (wr_mt || tick) ? 16'd0 : ctrl_q[0] ? pcnt_q + 16'd1 : pcnt_q;
        mtimecmp_d = (wr && addr_i == 3'd2) ? {mtimecmp_q[63:32], wdata_i}
                   : (wr && addr_i == 3'd3) ? {wdata_i, mtimecmp_q[31:0]}
                   : mtimecmp_q;
        ctrl_d     = (wr && addr_i == 3'd4) ? wdata_i[1:0] : ctrl_q;
        rdata_d    = (addr_i == 3'd0) ? mtime_q[31:0]
                   : (addr_i == 3'd1) ? hi_rd
                   : (addr_i == 3'd2) ? mtimecmp_q[31:0]
                   : (addr_i == 3'd3) ? mtimecmp_q[63:32]
                   : (addr_i == 3'd4) ? {30'd0, ctrl_q}
                   : 32'd0;
    end

`ifdef CLINT_TIMER_SNAPSHOT_EN
    logic [31:0] shadow_q, shadow_d;

    assign shadow_d = (wr && addr_i == 3'd1) ? wdata_i
                    : (req_i && !we_i && addr_i == 3'd0) ? mtime_q[63:32]
                    : shadow_q;
    assign hi_rd    = shadow_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) shadow_q <= '0;
        else       shadow_q <= shadow_d;
    end
`else
    assign hi_rd = mtime_q[63:32];
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mtime_q    <= '0;
            mtimecmp_q <= {RST_CMP_HI, 32'hFFFF_FFFF};
            pcnt_q     <= '0;
            ctrl_q     <= 2'b01;
            rdata_o    <= '0;
            ack_o      <= 1'b0;
            ti_o       <= 1'b1;
        end else begin
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            pcnt_q     <= pcnt_d;
            ctrl_q     <= ctrl_d;
            ack_o      <= req_i;
            ti_o       <= ~match;
            if (req_i) rdata_o <= rdata_d;
        end
    end
endmodule

// File: tb/tb_clint_timer.sv
// tb_clint_timer: scoreboard bench for clint_timer with PRESCALE=1 and PRESCALE=4 instances
module tb_clint_timer;
    localparam logic [31:0] CMP_HI1 = 32'h8000_0000;
`ifdef CLINT_TIMER_SNAPSHOT_EN
    localparam logic [31:0] SNAP_HI = 32'd1;
`else
    localparam logic [31:0] SNAP_HI = 32'd2;
`endif

    typedef struct {
        int          inst;
        logic        chk;
        logic [31:0] exp;
        string       name;
        int          issue;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req = '0;
    logic [1:0]  we = '0;
    logic [1:0]  ack, ti;
    logic [2:0]  addr [2];
    logic [31:0] wdata [2];
    logic [31:0] rdata [2];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    txn_t        sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    clint_timer u0 (
        .clk_i(clk), .rst_i(rst), .req_i(req[0]), .we_i(we[0]), .addr_i(addr[0]),
        .wdata_i(wdata[0]), .rdata_o(rdata[0]), .ack_o(ack[0]), .ti_o(ti[0])
    );

    clint_timer #(.PRESCALE(4), .RST_CMP_HI(CMP_HI1)) u1 (
        .clk_i(clk), .rst_i(rst), .req_i(req[1]), .we_i(we[1]), .addr_i(addr[1]),
        .wdata_i(wdata[1]), .rdata_o(rdata[1]), .ack_o(ack[1]), .ti_o(ti[1])
    );

    task automatic cmp(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    task automatic push(input int d, input logic c, input logic [31:0] e, input string n);
        txn_t t;
        t.inst  = d;
        t.chk   = c;
        t.exp   = e;
        t.name  = n;
        t.issue = cyc;
        sb.push_back(t);
    endtask

    task automatic bus(input int d, input logic w, input logic [2:0] a, input logic [31:0] wd,
                       input logic [31:0] e, input string n);
        @(negedge clk);
        push(d, !w, e, n);
        req[d]   = 1'b1;
        we[d]    = w;
        addr[d]  = a;
        wdata[d] = wd;
        @(negedge clk);
        req[d] = 1'b0;
        we[d]  = 1'b0;
    endtask

    task automatic rd(input int d, input logic [2:0] a, input logic [31:0] e, input string n);
        bus(d, 1'b0, a, 32'd0, e, n);
    endtask

    task automatic wr(input int d, input logic [2:0] a, input logic [31:0] wd);
        bus(d, 1'b1, a, wd, 32'd0, "write");
    endtask

    initial begin
        txn_t t;
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (ack[d]) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL spurious_ack inst %0d: got ack=1 expected ack=0", d);
                    end else begin
                        t = sb.pop_front();
                        cmp({t.name, "_inst"}, 32'(d), 32'(t.inst));
                        cmp({t.name, "_ack_latency"}, 32'(cyc), 32'(t.issue + 1));
                        if (t.chk) cmp(t.name, rdata[d], t.exp);
                    end
                end
            end
        end
    end

    initial begin
        addr[0] = '0; addr[1] = '0; wdata[0] = '0; wdata[1] = '0;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            cmp("rst_ti", 32'(ti[d]), 32'd1);
            cmp("rst_ack", 32'(ack[d]), 32'd0);
            cmp("rst_rdata", rdata[d], 32'd0);
        end
        rst = 1'b0;

        // free-running count and reset register values
        repeat (100) @(negedge clk);
        cmp("idle_ti", 32'(ti[0]), 32'd1);
        rd(0, 3'd0, 32'd101, "mtime_lo_101");
        rd(0, 3'd1, 32'd0, "mtime_hi_rst");
        rd(0, 3'd4, 32'd1, "ctrl_rst");
        rd(0, 3'd3, 32'hFFFF_FFFF, "cmp_hi_rst");
        rd(0, 3'd2, 32'hFFFF_FFFF, "cmp_lo_rst");
        rd(1, 3'd3, CMP_HI1, "cmp_hi_param");

        // compare and interrupt latency
        wr(0, 3'd0, 32'd0);
        wr(0, 3'd3, 32'd0);
        wr(0, 3'd2, 32'd20);
        repeat (16) @(negedge clk);
        cmp("ti_at_mtime20", 32'(ti[0]), 32'd1);
        @(negedge clk);
        cmp("ti_fall", 32'(ti[0]), 32'd0);
        repeat (5) @(negedge clk);
        cmp("ti_hold", 32'(ti[0]), 32'd0);
        wr(0, 3'd3, 32'd1);
        cmp("ti_still_low", 32'(ti[0]), 32'd0);
        @(negedge clk);
        cmp("ti_rise", 32'(ti[0]), 32'd1);

        // 64-bit wrap
        wr(0, 3'd3, 32'hFFFF_FFFF);
        wr(0, 3'd2, 32'hFFFF_FFFF);
        wr(0, 3'd1, 32'hFFFF_FFFF);
        wr(0, 3'd0, 32'hFFFF_FFFE);
        cmp("ti_before_wrap", 32'(ti[0]), 32'd1);
        @(negedge clk);
        rd(0, 3'd0, 32'd0, "wrap_lo");
        rd(0, 3'd1, 32'd0, "wrap_hi");
        cmp("ti_after_wrap", 32'(ti[0]), 32'd1);

        // autoclr: period of 11 ticks with mtimecmp=10
        wr(0, 3'd4, 32'd3);
        wr(0, 3'd3, 32'd0);
        wr(0, 3'd2, 32'd10);
        wr(0, 3'd0, 32'd0);
        for (int j = 1; j <= 22; j++) begin
            @(negedge clk);
            cmp($sformatf("autoclr_ti_%0d", j), 32'(ti[0]), (j == 11 || j == 22) ? 32'd0 : 32'd1);
        end
        rd(0, 3'd0, 32'd1, "autoclr_mtime");
        rd(0, 3'd4, 32'd3, "ctrl_autoclr");

        // lo-then-hi read across a carry
        wr(0, 3'd3, 32'hFFFF_FFFF);
        wr(0, 3'd4, 32'd1);
        wr(0, 3'd1, 32'd1);
        wr(0, 3'd0, 32'hFFFF_FFFE);
        rd(0, 3'd0, 32'hFFFF_FFFF, "snap_lo");
        rd(0, 3'd1, SNAP_HI, "snap_hi");

        // prescaler, enable and tick/write collision on the PRESCALE=4 instance
        wr(1, 3'd4, 32'd0);
        wr(1, 3'd0, 32'd100);
        rd(1, 3'd0, 32'd100, "frozen");
        repeat (50) @(negedge clk);
        rd(1, 3'd0, 32'd100, "frozen_50");
        wr(1, 3'd4, 32'd1);
        rd(1, 3'd0, 32'd100, "ps_a");
        rd(1, 3'd0, 32'd100, "ps_tick_preinc");
        rd(1, 3'd0, 32'd101, "ps_b");
        rd(1, 3'd0, 32'd101, "ps_c");
        rd(1, 3'd0, 32'd102, "ps_d");
        wr(1, 3'd0, 32'd500);
        rd(1, 3'd0, 32'd500, "tick_write_wins");
        rd(1, 3'd0, 32'd500, "tick_write_hold");
        rd(1, 3'd0, 32'd501, "tick_write_next");

        // back-to-back reads, reserved addresses, ctrl upper bits
        @(negedge clk);
        push(1, 1'b1, 32'd1, "b2b_ctrl");
        req[1] = 1'b1; we[1] = 1'b0; addr[1] = 3'd4;
        @(negedge clk);
        push(1, 1'b1, 32'd0, "b2b_rsvd5");
        addr[1] = 3'd5;
        @(negedge clk);
        push(1, 1'b1, CMP_HI1, "b2b_cmp_hi");
        addr[1] = 3'd3;
        @(negedge clk);
        req[1] = 1'b0;
        wr(1, 3'd6, 32'hDEAD_BEEF);
        rd(1, 3'd6, 32'd0, "rsvd6");
        wr(1, 3'd4, 32'hFFFF_FFFD);
        rd(1, 3'd4, 32'd1, "ctrl_mask");

        // reset during a request aborts it
        wr(0, 3'd4, 32'd3);
        @(negedge clk);
        req[0] = 1'b1; we[0] = 1'b0; addr[0] = 3'd0;
        #2 rst = 1'b1;
        @(negedge clk);
        req[0] = 1'b0;
        cmp("abort_ack", 32'(ack[0]), 32'd0);
        cmp("abort_rdata", rdata[0], 32'd0);
        cmp("abort_ti", 32'(ti[0]), 32'd1);
        rst = 1'b0;
        rd(0, 3'd4, 32'd1, "ctrl_after_rst");
        rd(1, 3'd3, CMP_HI1, "cmp_after_rst");

        repeat (3) @(negedge clk);
        cmp("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
